// File: rtl/pcie_dma_consumer.sv
// Multi-channel DMA sink: rate-throttled valid/ready intake per channel, 64-bit lane-sum
// checksum and 32-bit beat counter per channel, exposed through the app register space.
module pcie_dma_consumer #(
  parameter int NUM_CHAN   = 1,
  parameter int DATA_WIDTH = 64,
  parameter int RATE_WIDTH = 8,
  parameter int CSR_BASE   = 252
) (
  input  logic                           pcieClk_in,
  input  logic                           pcieRstN_in,
  input  logic                           cpuWrValid_in,
  input  logic [7:0]                     cpuWrReg_in,
  input  logic [31:0]                    cpuWrData_in,
  input  logic                           cpuRdValid_in,
  input  logic [7:0]                     cpuRdReg_in,
  output logic [31:0]                    cpuRdData_out,
  output logic                           cpuRdValid_out,
  input  logic [NUM_CHAN*DATA_WIDTH-1:0] rxData_in,
  input  logic [NUM_CHAN-1:0]            rxValid_in,
  output logic [NUM_CHAN-1:0]            rxReady_out
);

  localparam int LANES = DATA_WIDTH / 32;

  typedef enum logic {ST_ACCEPT, ST_WAIT} state_t;

  state_t                r_state    [NUM_CHAN];
  state_t                w_stateNxt [NUM_CHAN];
  logic [RATE_WIDTH-1:0] r_rate     [NUM_CHAN];
  logic [RATE_WIDTH-1:0] r_cd       [NUM_CHAN];
  logic [RATE_WIDTH-1:0] w_cdNxt    [NUM_CHAN];
  logic [63:0]           r_csum     [NUM_CHAN];
  logic [31:0]           r_shadow   [NUM_CHAN];
  logic [31:0]           r_count    [NUM_CHAN];
  logic [63:0]           w_laneSum  [NUM_CHAN];

  logic [NUM_CHAN-1:0] w_ready;
  logic [NUM_CHAN-1:0] w_accept;
  logic [NUM_CHAN-1:0] w_wrRate;
  logic [NUM_CHAN-1:0] w_clr;
  logic [NUM_CHAN-1:0] w_rdLsw;
  logic [31:0]         w_rdMux;
  logic [31:0]         r_rdData;
  logic                r_rdValid;
  logic                r_live;
  logic                w_unused;

  // Write data bits above the rate field carry no meaning.
  assign w_unused = ^{cpuWrData_in, 1'b0};

  function automatic logic [7:0] chan_base(input int unsigned c);
    return 8'(CSR_BASE - 4 * int'(c));
  endfunction

  always_comb begin
    for (int unsigned c = 0; c < NUM_CHAN; c++) begin
      w_laneSum[c] = '0;
      for (int unsigned l = 0; l < LANES; l++)
        w_laneSum[c] = w_laneSum[c] + 64'(rxData_in[c*DATA_WIDTH + l*32 +: 32]);
      w_ready[c]  = r_live && (r_state[c] == ST_ACCEPT);
      w_accept[c] = w_ready[c] && rxValid_in[c];
      w_wrRate[c] = cpuWrValid_in && (cpuWrReg_in == chan_base(c) + 8'd1);
      w_clr[c]    = cpuWrValid_in && (cpuWrReg_in == chan_base(c) + 8'd2);
      w_rdLsw[c]  = cpuRdValid_in && (cpuRdReg_in == chan_base(c) + 8'd2);
    end
  end

  assign rxReady_out = w_ready;

  always_comb begin
    for (int unsigned c = 0; c < NUM_CHAN; c++) begin
      w_stateNxt[c] = r_state[c];
      w_cdNxt[c]    = r_cd[c];
      if (r_state[c] == ST_ACCEPT) begin
        if (w_accept[c] && (r_rate[c] != '0)) begin
          w_cdNxt[c]    = r_rate[c];
          w_stateNxt[c] = ST_WAIT;
        end
      end else begin
        w_cdNxt[c] = r_cd[c] - RATE_WIDTH'(1);
        if (r_cd[c] == RATE_WIDTH'(1))
          w_stateNxt[c] = ST_ACCEPT;
      end
    end
  end

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      for (int unsigned c = 0; c < NUM_CHAN; c++) begin
        r_state[c] <= ST_ACCEPT;
        r_cd[c]    <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CHAN; c++) begin
        r_state[c] <= w_stateNxt[c];
        r_cd[c]    <= w_cdNxt[c];
      end
    end
  end

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      r_live <= 1'b0;
      for (int unsigned c = 0; c < NUM_CHAN; c++) begin
        r_rate[c]   <= '0;
        r_csum[c]   <= '0;
        r_shadow[c] <= '0;
        r_count[c]  <= '0;
      end
    end else begin
      r_live <= 1'b1;
      for (int unsigned c = 0; c < NUM_CHAN; c++) begin
        if (w_wrRate[c])
          r_rate[c] <= cpuWrData_in[RATE_WIDTH-1:0];
        // A clear coinciding with an accept restarts from that beat alone.
        if (w_clr[c]) begin
          r_csum[c]  <= w_accept[c] ? w_laneSum[c] : '0;
          r_count[c] <= w_accept[c] ? 32'd1 : 32'd0;
        end else if (w_accept[c]) begin
          r_csum[c]  <= r_csum[c] + w_laneSum[c];
          r_count[c] <= r_count[c] + 32'd1;
        end
        if (w_rdLsw[c])
          r_shadow[c] <= r_csum[c][63:32];
      end
    end
  end

  always_comb begin
    w_rdMux = '0;
    for (int unsigned c = 0; c < NUM_CHAN; c++) begin
      if (cpuRdReg_in == chan_base(c))
        w_rdMux = r_count[c];
      else if (cpuRdReg_in == chan_base(c) + 8'd1)
        w_rdMux = 32'(r_rate[c]);
      else if (cpuRdReg_in == chan_base(c) + 8'd2)
        w_rdMux = r_csum[c][31:0];
      else if (cpuRdReg_in == chan_base(c) + 8'd3)
        w_rdMux = r_shadow[c];
    end
  end

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
    end else begin
      r_rdValid <= cpuRdValid_in;
      r_rdData  <= cpuRdValid_in ? w_rdMux : '0;
    end
  end

  assign cpuRdData_out  = r_rdData;
  assign cpuRdValid_out = r_rdValid;

endmodule
